cpm_delta_rd_ctrl: RTL and testbench



---
 rtl/cpm_delta_rd_ctrl.sv | 124 ++++++++++++
 tb/tb_cpm_delta_rd_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpm_delta_rd_ctrl.sv
// Streams a range of delta words from the CPM delta SRAM, reconstructs absolute per-lane values
// by running accumulation, and hands them out through a 2-entry skid buffer. Saturation: CPM_DELTA_SAT_EN.
module cpm_delta_rd_ctrl #(
  parameter int SRAM_DEPTH_BIT = 6,
  parameter int NUM            = 4,
  parameter int DW             = 7,
  parameter int AW             = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [SRAM_DEPTH_BIT-1:0] cfg_base_addr,
  input  logic [SRAM_DEPTH_BIT:0]   cfg_len,
  output logic                      busy,
  output logic                      done,
  output logic [SRAM_DEPTH_BIT-1:0] ram_addr_r,
  output logic                      ram_read_en,
  input  logic [NUM*DW-1:0]         ram_data_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM*AW-1:0]         out_data,
  output logic                      out_last
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                    state;
  logic [SRAM_DEPTH_BIT-1:0] base;
  logic [SRAM_DEPTH_BIT:0]   len;
  logic [SRAM_DEPTH_BIT:0]   rd_cnt;
  logic [SRAM_DEPTH_BIT:0]   out_cnt;
  logic [1:0]                occ;
  logic                      inflight;
  logic [NUM*AW-1:0]         acc;
  logic [NUM*AW-1:0]         acc_nxt;
  logic [NUM*AW-1:0]         buf0;
  logic [NUM*AW-1:0]         buf1;
  logic                      pop;
  logic                      push;
  logic [2:0]                occ_after;
  logic                      last_issue;

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign out_valid = (occ != 2'd0);
  assign out_data  = buf0;
  assign out_last  = out_valid && (out_cnt == len - 1'b1);
  assign pop       = out_valid && out_ready;
  assign push      = inflight;

  // Occupancy the buffer would have once the read already in flight lands and this cycle's pop leaves.
  assign occ_after   = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign ram_read_en = (state == S_RUN) && (rd_cnt < len) && (occ_after < 3'd2);
  assign ram_addr_r  = base + rd_cnt[SRAM_DEPTH_BIT-1:0];
  assign last_issue  = ram_read_en && (rd_cnt == len - 1'b1);

  for (genvar k = 0; k < NUM; k++) begin : g_lane
    logic signed [AW-1:0] a;
    logic signed [DW-1:0] d;
    assign a = acc[k*AW +: AW];
    assign d = ram_data_out[k*DW +: DW];
`ifdef CPM_DELTA_SAT_EN
    logic signed [AW:0] s;
    assign s = (AW+1)'(a) + (AW+1)'(d);
    assign acc_nxt[k*AW +: AW] = (s[AW] != s[AW-1]) ?
                                 (s[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}}) :
                                 s[AW-1:0];
`else
    logic signed [AW-1:0] s;
    assign s = a + AW'(d);
    assign acc_nxt[k*AW +: AW] = s;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      base     <= '0;
      len      <= '0;
      rd_cnt   <= '0;
      out_cnt  <= '0;
      occ      <= '0;
      inflight <= 1'b0;
      acc      <= '0;
      buf0     <= '0;
      buf1     <= '0;
    end else begin
      inflight <= ram_read_en;
      if (ram_read_en) rd_cnt <= rd_cnt + 1'b1;
      if (pop) out_cnt <= out_cnt + 1'b1;
      if (push) acc <= acc_nxt;

      if (pop) buf0 <= buf1;
      if (push) begin
        if (occ == 2'd0 || (occ == 2'd1 && pop)) buf0 <= acc_nxt;
        else buf1 <= acc_nxt;
      end
      occ <= occ + {1'b0, push} - {1'b0, pop};

      case (state)
        S_IDLE: begin
          if (start) begin
            base    <= cfg_base_addr;
            len     <= cfg_len;
            rd_cnt  <= '0;
            out_cnt <= '0;
            acc     <= '0;
            state   <= S_RUN;
          end
        end
        // A zero-length job idles one cycle here so done lands two cycles after start.
        S_RUN: begin
          if (len == '0) state <= S_DONE;
          else if (last_issue) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (pop && out_last) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpm_delta_rd_ctrl.sv
// Bench for cpm_delta_rd_ctrl: table of jobs plus randomized jobs, all checked against an integer model.
module tb_cpm_delta_rd_ctrl;
  localparam int DB = 6, NUM = 4, DW = 7, AW = 12, DEPTH = 64;
  localparam int AMAX = (1 << (AW - 1)) - 1;
  localparam int AMIN = -(1 << (AW - 1));

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [DB-1:0]     cfg_base_addr = '0;
  logic [DB:0]       cfg_len = '0;
  logic              busy, done, ram_read_en, out_valid, out_last;
  logic              out_ready = 1'b0;
  logic [DB-1:0]     ram_addr_r;
  logic [NUM*DW-1:0] ram_data_out = '0;
  logic [NUM*AW-1:0] out_data;

  logic [NUM*DW-1:0] mem [DEPTH];
  logic [NUM*AW-1:0] exp_q[$];
  logic [NUM*AW-1:0] got_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  cpm_delta_rd_ctrl #(.SRAM_DEPTH_BIT(DB), .NUM(NUM), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_base_addr(cfg_base_addr), .cfg_len(cfg_len),
    .busy(busy), .done(done), .ram_addr_r(ram_addr_r), .ram_read_en(ram_read_en),
    .ram_data_out(ram_data_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_read_en) ram_data_out <= mem[ram_addr_r];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference: plain integer running sums per lane, clamped or folded back into AW-bit range.
  function automatic void model(input int base, input int len);
    int acc [NUM];
    logic [NUM*AW-1:0] w;
    logic [DW-1:0] draw;
    logic [AW-1:0] t;
    exp_q.delete();
    foreach (acc[k]) acc[k] = 0;
    for (int i = 0; i < len; i++) begin
      w = '0;
      for (int k = 0; k < NUM; k++) begin
        draw = mem[(base + i) % DEPTH][k*DW +: DW];
        acc[k] = acc[k] + int'($signed(draw));
`ifdef CPM_DELTA_SAT_EN
        if (acc[k] > AMAX) acc[k] = AMAX;
        if (acc[k] < AMIN) acc[k] = AMIN;
`else
        if (acc[k] > AMAX) acc[k] = acc[k] - (1 << AW);
        else if (acc[k] < AMIN) acc[k] = acc[k] + (1 << AW);
`endif
        t = acc[k][AW-1:0];
        w[k*AW +: AW] = t;
      end
      exp_q.push_back(w);
    end
  endfunction

  task automatic fill_mem(input int dmode, input int base);
    int b [4] = '{1, 2, -3, 5};
    for (int a = 0; a < DEPTH; a++) begin
      mem[a] = (dmode == 0) ? (NUM*DW)'($urandom) : '0;
      if (dmode == 2) mem[a][DW-1:0] = DW'(63);
    end
    if (dmode == 1) for (int i = 0; i < 4; i++) mem[(base + i) % DEPTH][DW-1:0] = DW'(b[i]);
  endtask

  task automatic run_job(input int base, input int len, input int rmode, input int sstart,
                         input int exp_fv, input int exp_done);
    int c = 0, idx = 0, reads = 0, first_rd = -1, first_v = -1, done_c = -1, last_hs = -1;
    logic stall = 1'b0;
    logic [NUM*AW-1:0] prev = '0;
    model(base, len);
    got_q.delete();
    @(negedge clk);
    start = 1'b1; cfg_base_addr = DB'(base); cfg_len = (DB+1)'(len); out_ready = 1'b0;
    while (done_c < 0 && c < 600) begin
      @(negedge clk);
      c++;
      start = (c == sstart);
      if (c == sstart) begin cfg_base_addr = DB'(base + 7); cfg_len = 3; end
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((c - 1) % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      check("busy", 64'(busy), 64'(1));
      if (stall) check("stall_hold", 64'(out_data), 64'(prev));
      if (!out_valid) check("last_qual", 64'(out_last), 64'(0));
      if (ram_read_en) begin
        if (first_rd < 0) first_rd = c;
        check("rd_addr", 64'(ram_addr_r), 64'((base + reads) % DEPTH));
        reads++;
      end
      if (out_valid && first_v < 0) first_v = c;
      if (out_valid && out_ready) begin
        if (idx < len) begin
          check("data", 64'(out_data), 64'(exp_q[idx]));
          check("last", 64'(out_last), 64'(idx == len - 1));
        end else fail_now("extra_word");
        got_q.push_back(out_data);
        last_hs = c;
        idx++;
      end
      stall = out_valid && !out_ready;
      prev  = out_data;
      if (done) done_c = c;
    end
    if (done_c < 0) fail_now("done_timeout");
    check("words", 64'(idx), 64'(len));
    check("reads", 64'(reads), 64'(len));
    if (len > 0) check("done_after_last", 64'(done_c), 64'(last_hs + 1));
    if (len > 0) check("first_rd", 64'(first_rd), 64'(1));
    if (exp_fv != 0) check("first_valid", 64'(first_v), 64'(exp_fv));
    if (exp_done != 0) check("done_cycle", 64'(done_c), 64'(exp_done));
    @(negedge clk);
    start = 1'b0;
    #1;
    check("done_pulse", 64'(done), 64'(0));
    check("idle_after", 64'(busy), 64'(0));
    @(negedge clk);
    #1;
    check("idle_after2", 64'(busy | ram_read_en | out_valid), 64'(0));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_rden"}, 64'(ram_read_en), 64'(0));
    check({tag, "_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_last"}, 64'(out_last), 64'(0));
    check({tag, "_addr"}, 64'(ram_addr_r), 64'(0));
    check({tag, "_data"}, 64'(out_data), 64'(0));
  endtask

  typedef struct {
    int base; int len; int rmode; int dmode; int sstart; int exp_fv; int exp_done;
  } vec_t;

  vec_t tbl [8];
  logic [AW-1:0] lane0;
  logic [AW-1:0] exp33;
  logic [AW-1:0] exp40;

  initial begin
    tbl[0] = '{0,  4,  0, 1, 0, 3, 7};   // basic lane0 deltas
    tbl[1] = '{62, 4,  0, 0, 0, 3, 7};   // address wrap
    tbl[2] = '{10, 8,  1, 0, 0, 0, 0};   // ready 1,0,0 pattern
    tbl[3] = '{5,  0,  0, 0, 0, 0, 2};   // zero length
    tbl[4] = '{20, 5,  0, 0, 2, 3, 8};   // start while busy
    tbl[5] = '{30, 3,  0, 0, 6, 3, 6};   // start in the done cycle
    tbl[6] = '{0,  40, 0, 2, 0, 3, 43};  // lane0 overflow
    tbl[7] = '{63, 64, 2, 0, 0, 0, 0};   // full depth, random ready

    #1;
    check_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      fill_mem(tbl[i].dmode, tbl[i].base);
      run_job(tbl[i].base, tbl[i].len, tbl[i].rmode, tbl[i].sstart, tbl[i].exp_fv, tbl[i].exp_done);
      if (i == 0 && got_q.size() == 4) begin
        lane0 = got_q[1][AW-1:0]; check("basic_w2", 64'(lane0), 64'(3));
        lane0 = got_q[2][AW-1:0]; check("basic_w3", 64'(lane0), 64'(0));
        lane0 = got_q[3][AW-1:0]; check("basic_w4", 64'(lane0), 64'(5));
      end
      if (i == 6 && got_q.size() == 40) begin
`ifdef CPM_DELTA_SAT_EN
        exp33 = 12'h7FF; exp40 = 12'h7FF;
`else
        exp33 = 12'h81F; exp40 = 12'h9D8;
`endif
        lane0 = got_q[31][AW-1:0]; check("ovf_w32", 64'(lane0), 64'(2016));
        lane0 = got_q[32][AW-1:0]; check("ovf_w33", 64'(lane0), 64'(exp33));
        lane0 = got_q[39][AW-1:0]; check("ovf_w40", 64'(lane0), 64'(exp40));
      end
    end

    // Reset in the middle of a long job, then a short job must start from zeroed accumulators.
    fill_mem(0, 0);
    @(negedge clk);
    start = 1'b1; cfg_base_addr = 0; cfg_len = 16; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("post_rst_quiet", 64'(done | busy), 64'(0));
    end
    run_job(0, 2, 0, 0, 3, 5);

    for (int r = 0; r < 6; r++) begin
      fill_mem(0, 0);
      run_job(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 20)), 2, 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
